// File: rtl/ahb_master_seq_if.sv
// AHB-Lite bus bundle between the transfer sequencer (master side) and the
// slave/bridge port it drives.
interface ahb_master_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] Haddr;
  logic [1:0]        Htrans;
  logic              Hwrite;
  logic [2:0]        Hsize;
  logic [2:0]        Hburst;
  logic [DATA_W-1:0] Hwdata;
  logic              Hreadyin;
  logic              Hreadyout;
  logic [1:0]        Hresp;
  logic [DATA_W-1:0] Hrdata;

  modport master (
    output Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hreadyin,
    input  Hreadyout, Hresp, Hrdata
  );

  modport slave (
    input  Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hreadyin,
    output Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb_master_seq.sv
// AHB-Lite master transfer sequencer: turns one command (SINGLE, INCR4/8,
// WRAP4/8, read or write) into a pipelined address/data-phase sequence.
module ahb_master_seq #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [1:0]        cmd_size,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [2:0]        fsm_state,
  ahb_master_seq_if.master  bus
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_BURST = 3'd2,
    S_LAST  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  beats_left;
  logic [3:0]  burst_len;
  logic        wrap;
  logic        dp_valid;

  logic [3:0]        cmd_len;
  logic              cmd_wrap;
  logic [ADDR_W-1:0] cmd_aligned;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr_next;
  logic [ADDR_W-1:0] next_addr;
  logic              addr_ok;
  logic              dp_err;
  logic              dp_done;

  // Command handshake: a command transfers on the rising edge where
  // cmd_valid && cmd_ready; cmd_ready is high only while the sequencer is idle.
  assign cmd_ready = (state == S_IDLE);
  assign fsm_state = state;

  always_comb begin
    cmd_len  = 4'd1;
    cmd_wrap = 1'b0;
    case (cmd_burst)
      3'b010: begin cmd_len = 4'd4; cmd_wrap = 1'b1; end
      3'b011: begin cmd_len = 4'd4; cmd_wrap = 1'b0; end
      3'b100: begin cmd_len = 4'd8; cmd_wrap = 1'b1; end
      3'b101: begin cmd_len = 4'd8; cmd_wrap = 1'b0; end
      default: begin cmd_len = 4'd1; cmd_wrap = 1'b0; end
    endcase
  end

  assign cmd_aligned = cmd_addr & ~((ADDR_W'(1) << cmd_size) - ADDR_W'(1));

  // Wrap boundary is beats*step bytes; only the bits under it roll over.
  assign step      = ADDR_W'(1) << bus.Hsize;
  assign wrap_mask = (ADDR_W'(burst_len) << bus.Hsize) - ADDR_W'(1);
  assign incr_next = bus.Haddr + step;
  assign next_addr = wrap ? ((bus.Haddr & ~wrap_mask) | (incr_next & wrap_mask))
                          : incr_next;

  assign dp_err  = dp_valid && (bus.Hresp == RESP_ERR);
  assign dp_done = dp_valid && bus.Hreadyout && (bus.Hresp == RESP_OKAY);
  assign addr_ok = (state == S_ADDR || state == S_BURST) &&
                   (bus.Htrans != TR_IDLE) && bus.Hreadyout && !dp_err;
  assign wr_pop  = addr_ok && bus.Hwrite;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state        <= S_IDLE;
      beats_left   <= 4'd0;
      burst_len    <= 4'd0;
      wrap         <= 1'b0;
      dp_valid     <= 1'b0;
      bus.Haddr    <= '0;
      bus.Htrans   <= TR_IDLE;
      bus.Hwrite   <= 1'b0;
      bus.Hsize    <= 3'd0;
      bus.Hburst   <= 3'd0;
      bus.Hwdata   <= '0;
      bus.Hreadyin <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.Hreadyin <= 1'b1;
      rd_valid     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;

      if (dp_done && !bus.Hwrite) begin
        rd_data  <= bus.Hrdata;
        rd_valid <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            bus.Haddr  <= cmd_aligned;
            bus.Htrans <= TR_NONSEQ;
            bus.Hwrite <= cmd_write;
            bus.Hsize  <= {1'b0, cmd_size};
            bus.Hburst <= cmd_burst;
            burst_len  <= cmd_len;
            beats_left <= cmd_len;
            wrap       <= cmd_wrap;
            dp_valid   <= 1'b0;
            state      <= S_ADDR;
          end
        end

        S_ADDR, S_BURST, S_LAST: begin
          if (dp_err) begin
            // Pending address is dropped whether or not the slave took it.
            bus.Htrans <= TR_IDLE;
            if (bus.Hreadyout) begin
              done     <= 1'b1;
              err      <= 1'b1;
              dp_valid <= 1'b0;
              state    <= S_IDLE;
            end else begin
              state <= S_ERR;
            end
          end else if (addr_ok) begin
            dp_valid <= 1'b1;
            if (bus.Hwrite) bus.Hwdata <= wr_data;
            if (beats_left == 4'd1) begin
              bus.Htrans <= TR_IDLE;
              state      <= S_LAST;
            end else begin
              bus.Haddr  <= next_addr;
              bus.Htrans <= (!wrap && next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
              beats_left <= beats_left - 4'd1;
              state      <= S_BURST;
            end
          end else if (state == S_LAST && dp_done) begin
            done     <= 1'b1;
            dp_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end

        S_ERR: begin
          if (bus.Hreadyout) begin
            done     <= 1'b1;
            err      <= 1'b1;
            dp_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ahb_master_seq.md
Name: ahb_master_seq

Overview:
- Synthesizable AHB-Lite master transfer sequencer. It replaces the task-driven master stimulus with RTL that turns one command (single, INCR4/8 or WRAP4/8, read or write) into a pipelined AHB address/data-phase sequence.
- It sits between a local command/data interface and the AHB slave side of the bridge: it drives Haddr/Htrans/Hwrite/Hwdata/Hreadyin and consumes Hreadyout/Hresp/Hrdata.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- Hclk  input  1  bus clock, all logic on rising edge
- Hresetn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block accepts a command this cycle
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_W  start address
- cmd_burst  input  3  000 SINGLE, 010 WRAP4, 011 INCR4, 100 WRAP8, 101 INCR8; other codes are treated as SINGLE
- cmd_size  input  2  00 byte, 01 half, 10 word
- wr_data  input  DATA_W  write data for the current beat
- wr_pop  output  1  wr_data consumed this edge
- rd_data  output  DATA_W  registered read data
- rd_valid  output  1  rd_data valid (one-cycle pulse per beat)
- done  output  1  one-cycle pulse: command finished
- err  output  1  qualifies done: ERROR response seen
- Haddr  output  ADDR_W  AHB address
- Htrans  output  2  00 IDLE, 10 NONSEQ, 11 SEQ
- Hwrite  output  1  AHB write
- Hsize  output  3  {1'b0, cmd_size}
- Hburst  output  3  latched cmd_burst
- Hwdata  output  DATA_W  AHB write data
- Hreadyin  output  1  driven 1 whenever out of reset
- Hreadyout  input  1  slave ready / phase completion
- Hresp  input  2  00 OKAY, 01 ERROR
- Hrdata  input  DATA_W  read data

Behaviour:
- Reset (async, Hresetn=0): state IDLE. All of the following are 0: Htrans, Haddr, Hwrite, Hsize, Hburst, Hwdata, rd_data, rd_valid, wr_pop, done, err, Hreadyin. Reset mid-burst abandons the burst immediately; no done is generated.
- cmd_ready = (state==IDLE). The command is accepted on the edge where cmd_valid && cmd_ready. The command fields are latched; Haddr = cmd_addr with its low bits aligned to the size (forced to 0), and Htrans = NONSEQ from the next cycle.
- Beat count: SINGLE 1, x4 4, x8 8. Step = 1<<cmd_size.
- States:
  - IDLE: waits for an accepted command.
  - ADDR: the first beat's address phase is being driven.
  - BURST: beats 2..N are being driven as SEQ.
  - LAST: only the data phase of the final beat is outstanding; Htrans = IDLE.
  - ERR: the second cycle of an ERROR response is being absorbed.
- Address phase acceptance: an address phase is accepted on the edge where Htrans!=IDLE && Hreadyout=1. Haddr, Htrans, Hwrite, Hsize and Hburst are held stable while Hreadyout=0.
- On each accepted beat:
  - For writes: wr_pop=1 in that cycle and Hwdata <= wr_data at that edge. Hwdata is then stable through the beat's data phase.
  - Haddr advances to the next beat address and Htrans = SEQ. After the last beat is accepted, Htrans = IDLE and the state goes to LAST.
- INCR addressing: next = Haddr + step. If next[9:0]==0 and beats remain, that beat is driven NONSEQ instead of SEQ (restart at the 1 KB boundary).
- WRAP addressing: the boundary is beats*step bytes. next = {Haddr upper bits, (Haddr low bits + step) mod boundary}; all beats are SEQ.
- Read data: on each completed read data phase (Hreadyout=1, Hresp=OKAY), rd_data <= Hrdata and rd_valid=1 in the next cycle. Latency is 1 cycle after the phase completes.
- Completion: done=1 with err=0 in the cycle after the final data phase completes OKAY; the state returns to IDLE at that point. A new command can be accepted no earlier than the cycle done is asserted, so at least 1 IDLE cycle lies between commands.
- ERROR response:
  - First cycle (Hresp=01, Hreadyout=0): Htrans is forced to IDLE from the next cycle, all remaining beats are cancelled, wr_pop stays 0, and the state goes to ERR.
  - Second cycle (Hresp=01, Hreadyout=1): done=1 and err=1 in the next cycle, then the state returns to IDLE. No rd_valid is generated for the errored beat.
- Simultaneous events:
  - A wait state on the last beat keeps the state in LAST, with Htrans=IDLE held.
  - An ERROR on a data phase while the next address is pending cancels that address, even if it was never accepted.
- Hreadyin: 1 from the first cycle after reset deassertion.

Test Plan:
- Single write: cmd_addr=32'h8000_0001, size byte, wr_data=8'hA3 -> Haddr=8000_0001 with NONSEQ for 1 cycle, Hwdata=A3 in the next cycle, wr_pop 1 pulse, done=1 with err=0 two cycles after acceptance.
- INCR4 write: addr 8000_0000, size byte, Hreadyout=1 -> Haddr 0,1,2,3; Htrans NONSEQ,SEQ,SEQ,SEQ then IDLE; 4 wr_pop pulses; Hwdata lags the address by 1 cycle.
- WRAP4 read: addr 8000_0006, size byte -> Haddr 06,07,04,05; 4 rd_valid pulses carrying Hrdata; done=1 with err=0.
- INCR4 word write across the 1 KB boundary: addr 8000_03F8 -> Haddr 3F8,3FC,400,404; Htrans NONSEQ,SEQ,NONSEQ,SEQ.
- Wait states: Hreadyout=0 for 2 cycles on beat 2 of INCR4 -> Haddr/Htrans/Hwdata held; total completion is extended by exactly 2 cycles.
- Error and reset:
  - Hresp=01 on beat 2 of INCR8 -> Htrans=IDLE in the next cycle, no further beats, done=1 with err=1.
  - Hresetn=0 mid-burst -> all outputs 0 asynchronously, no done.
